bcd_operand_entry: RTL and testbench

- Sequential front end that feeds the two-digit BCD adder stage.
- Captures operand A, then operand B, from the 8 data switches on successive debounced presses of an enter push-button.
- Validates that every captured digit is legal BCD (0–9) and holds the accepted operands stable on registered outputs, with a valid flag, for the adder and HEX display stages downstream.

---
 rtl/bcd_operand_entry.sv | 155 +++++++++++++++
 tb/tb_bcd_operand_entry.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry.sv
// Two-operand BCD entry front end: debounces the enter key, captures A then B from the switches,
// validates each digit and holds the accepted operands on registered outputs.
module bcd_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] SW,
  input  logic       KEY_enter,
  output logic [3:0] A1,
  output logic [3:0] A0,
  output logic [3:0] B1,
  output logic [3:0] B0,
  output logic       valid,
  output logic       err,
  output logic [1:0] state
);

  localparam logic [1:0] GET_A = 2'b00;
  localparam logic [1:0] GET_B = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Key synchronizer and debounce
  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  // Operand and control registers
  logic [3:0] a1_q, a1_d, a0_q, a0_d;
  logic [3:0] b1_q, b1_d, b0_q, b0_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [1:0] state_q, state_d;
  logic       sw_legal;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Registered edge detect: capture happens one edge after the debounced level falls.
  assign press    = stable_prev_q & ~stable_q;
  assign sw_legal = (SW[7:4] <= 4'd9) && (SW[3:0] <= 4'd9);

  always_comb begin
    a1_d    = a1_q;
    a0_d    = a0_q;
    b1_d    = b1_q;
    b0_d    = b0_q;
    valid_d = valid_q;
    err_d   = err_q;
    state_d = state_q;
    case (state_q)
      GET_A: begin
        if (press) begin
          if (sw_legal) begin
            a1_d    = SW[7:4];
            a0_d    = SW[3:0];
            err_d   = 1'b0;
            state_d = GET_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_B: begin
        if (press) begin
          if (sw_legal) begin
            b1_d    = SW[7:4];
            b0_d    = SW[3:0];
            err_d   = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (press) begin
          if (sw_legal) begin
            // New entry: B is kept but marked stale by dropping valid.
            a1_d    = SW[7:4];
            a0_d    = SW[3:0];
            err_d   = 1'b0;
            valid_d = 1'b0;
            state_d = GET_B;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= KEY_enter;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      a1_q    <= 4'd0;
      a0_q    <= 4'd0;
      b1_q    <= 4'd0;
      b0_q    <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      state_q <= GET_A;
    end else begin
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      b1_q    <= b1_d;
      b0_q    <= b0_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign A1    = a1_q;
  assign A0    = a0_q;
  assign B1    = b1_q;
  assign B0    = b0_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Bench for bcd_operand_entry: directed scenarios then random key/switch traffic, every cycle
// compared against a run-length debounce model and an operand-entry model.
module tb_bcd_operand_entry;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [3:0] a1, a0, b1, b0;
  logic       valid, err;
  logic [1:0] state;

  bcd_operand_entry #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .SW       (sw),
    .KEY_enter(key),
    .A1       (a1),
    .A0       (a0),
    .B1       (b1),
    .B0       (b0),
    .valid    (valid),
    .err      (err),
    .state    (state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: key delay line, run length of disagreement, pending press, entry phase.
  int         k_d1, k_d2, m_stable, m_run, m_pend;
  int         m_phase;
  logic [3:0] m_a1, m_a0, m_b1, m_b0;
  bit         m_valid, m_err;

  function automatic void model_edge();
    int nxt;
    if (!resetn) begin
      k_d1 = 1; k_d2 = 1; m_stable = 1; m_run = 0; m_pend = 0;
      m_phase = 0; m_a1 = 0; m_a0 = 0; m_b1 = 0; m_b0 = 0; m_valid = 0; m_err = 0;
      return;
    end
    if (m_pend != 0) begin
      if (sw[7:4] > 4'd9 || sw[3:0] > 4'd9) begin
        m_err = 1;
      end else begin
        m_err = 0;
        if (m_phase == 1) begin
          m_b1 = sw[7:4]; m_b0 = sw[3:0]; m_valid = 1; m_phase = 2;
        end else begin
          m_a1 = sw[7:4]; m_a0 = sw[3:0]; m_valid = 0; m_phase = 1;
        end
      end
    end
    nxt = 0;
    if (k_d2 != m_stable) begin
      m_run++;
      if (m_run == int'(D)) begin
        if (m_stable == 1) nxt = 1;
        m_stable = k_d2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    k_d2 = k_d1;
    k_d1 = int'(key);
    m_pend = nxt;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("A1", a1, m_a1);
    chk("A0", a0, m_a0);
    chk("B1", b1, m_b1);
    chk("B0", b0, m_b0);
    chk("valid", {3'b0, valid}, {3'b0, m_valid});
    chk("err", {3'b0, err}, {3'b0, m_err});
    chk("state", {2'b0, state}, 4'(m_phase));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [7:0] v);
    sw = v;
    key = 1'b0;
    cycles(int'(D) + 5);
    key = 1'b1;
    cycles(int'(D) + 5);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycles(2);
    resetn = 1'b1;
  endtask

  initial begin
    // 1: reset with key held low, then the held key counts as a press once reset lifts
    resetn = 1'b0; key = 1'b0; sw = 8'h12;
    @(negedge clk);
    cycles(3);
    chk("rst_state", {2'b0, state}, 4'h0);
    chk("rst_valid", {3'b0, valid}, 4'h0);
    chk("rst_a1", a1, 4'h0);
    resetn = 1'b1;
    cycles(6);
    chk("rst_nocap", {2'b0, state}, 4'h0);
    cycles(1);
    chk("rst_cap", {2'b0, state}, 4'h1);
    key = 1'b1;
    cycles(10);

    // 2: normal entry with exact latency on the second press
    do_reset();
    press(8'h47);
    chk("t2_a1", a1, 4'h4);
    chk("t2_a0", a0, 4'h7);
    chk("t2_state_a", {2'b0, state}, 4'h1);
    sw = 8'h85; key = 1'b0;
    cycles(6);
    chk("t2_early", {2'b0, state}, 4'h1);
    cycles(1);
    chk("t2_state_b", {2'b0, state}, 4'h2);
    chk("t2_b1", b1, 4'h8);
    chk("t2_b0", b0, 4'h5);
    chk("t2_valid", {3'b0, valid}, 4'h1);
    key = 1'b1;
    cycles(10);

    // 3: bounce then clean hold, then a too-short press
    sw = 8'h61;
    for (int i = 0; i < 5; i++) begin
      key = 1'b0; cycles(2);
      key = 1'b1; cycles(2);
    end
    key = 1'b0;
    cycles(6);
    chk("t3_nocap", {2'b0, state}, 4'h2);
    cycles(1);
    chk("t3_cap", {2'b0, state}, 4'h1);
    chk("t3_a1", a1, 4'h6);
    key = 1'b1;
    cycles(10);
    sw = 8'h22;
    key = 1'b0; cycles(3);
    key = 1'b1; cycles(10);
    chk("t3_short", {2'b0, state}, 4'h1);
    chk("t3_short_b1", b1, 4'h8);

    // 4: illegal digit rejected in GET_A
    do_reset();
    press(8'h3C);
    chk("t4_err", {3'b0, err}, 4'h1);
    chk("t4_state", {2'b0, state}, 4'h0);
    press(8'h39);
    chk("t4_a0", a0, 4'h9);
    chk("t4_err_clr", {3'b0, err}, 4'h0);

    // 5: restart from DONE keeps stale B
    do_reset();
    press(8'h12);
    press(8'h34);
    press(8'h99);
    chk("t5_a1", a1, 4'h9);
    chk("t5_b0", b0, 4'h4);
    chk("t5_valid", {3'b0, valid}, 4'h0);
    chk("t5_state", {2'b0, state}, 4'h1);

    // 6: reset mid-debounce discards both the operand and the press
    do_reset();
    press(8'h55);
    sw = 8'h77; key = 1'b0;
    cycles(4);
    resetn = 1'b0;
    cycles(1);
    resetn = 1'b1; key = 1'b1;
    cycles(10);
    chk("t6_a1", a1, 4'h0);
    chk("t6_state", {2'b0, state}, 4'h0);

    // Random traffic: arbitrary press/release lengths, switch codes and occasional reset
    for (int n = 0; n < 60; n++) begin
      sw = 8'($urandom_range(0, 255));
      key = 1'b0;
      cycles(int'($urandom_range(1, 9)));
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom_range(0, 255));
      key = 1'b1;
      cycles(int'($urandom_range(1, 9)));
      if ($urandom_range(0, 19) == 0) begin
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
